seq_gen: RTL and testbench

Serial sequence generator: accepts a parallel word through a ready/load handshake and drives it out LSB-first, one bit per clock, on the single-bit `seq` line.
- This is the stimulus source for the sequence-detector blocks (`mealy`/`moore`); its `seq` output connects directly to their `seq` input.
- It replaces hand-written shift loops in benches and lets detectors be driven back-to-back in system-level tests.

---
 rtl/seq_gen.sv | 141 ++++++++++++++
 tb/tb_seq_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// Serial sequence generator: takes a parallel word on a load/ready handshake and shifts it out LSB-first on seq.
// Optional build macro SEQ_GEN_LOOP_EN makes the block resend the retained word forever instead of single-shot.
module seq_gen #(
  parameter int WIDTH = 20,
  parameter int GAP   = 0,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             seq,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PENULT_IDX = CNT_W'(WIDTH - 2);
  localparam logic [3:0]       GAP_LAST   = 4'((GAP > 0) ? GAP - 1 : 0);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             seq_q, seq_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
`ifdef SEQ_GEN_LOOP_EN
  logic [WIDTH-1:0] word_q, word_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      seq_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
`ifdef SEQ_GEN_LOOP_EN
      word_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      seq_q   <= seq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
`ifdef SEQ_GEN_LOOP_EN
      word_q  <= word_d;
`endif
    end
  end

  // seq always mirrors the bit that was at shreg[0] one edge earlier, so the register holds the not-yet-sent bits.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    seq_d   = seq_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
`ifdef SEQ_GEN_LOOP_EN
    word_d  = word_q;
`endif
    case (state_q)
      S_IDLE: begin
        seq_d  = 1'b0;
        busy_d = 1'b0;
        cnt_d  = '0;
        if (load) begin
          state_d = S_SHIFT;
          shreg_d = data >> 1;
          seq_d   = data[0];
          busy_d  = 1'b1;
`ifdef SEQ_GEN_LOOP_EN
          word_d  = data;
`endif
        end
      end
      S_SHIFT: begin
        if (cnt_q != LAST_IDX) begin
          seq_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          done_d  = (cnt_q == PENULT_IDX);
        end else if (GAP > 0) begin
          state_d = S_GAP;
          seq_d   = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          gap_d   = '0;
        end else begin
`ifdef SEQ_GEN_LOOP_EN
          shreg_d = word_q >> 1;
          seq_d   = word_q[0];
          cnt_d   = '0;
`else
          state_d = S_IDLE;
          seq_d   = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
`endif
        end
      end
      S_GAP: begin
        seq_d  = 1'b0;
        busy_d = 1'b0;
        if (gap_q == GAP_LAST) begin
`ifdef SEQ_GEN_LOOP_EN
          state_d = S_SHIFT;
          shreg_d = word_q >> 1;
          seq_d   = word_q[0];
          busy_d  = 1'b1;
          cnt_d   = '0;
`else
          state_d = S_IDLE;
`endif
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready   = (state_q == S_IDLE) && rst;
  assign seq     = seq_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: instance 0 has GAP=0, instance 1 GAP=3, instance 2 (loop build only) GAP=2.
// Each expected cycle is packed as {ready, seq, busy, done, bit_cnt}.
module tb_seq_gen;

  localparam int W = 20;
`ifdef SEQ_GEN_LOOP_EN
  localparam int NI = 3;
`else
  localparam int NI = 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         load [NI];
  logic [W-1:0] data [NI];
  logic         rdy  [NI];
  logic         sq   [NI];
  logic         bz   [NI];
  logic         dn   [NI];
  logic [4:0]   bc   [NI];

  logic [8:0] expQ [$];
  int numChecks = 0;
  int numFails  = 0;

  always #5 clk = ~clk;

  seq_gen #(.WIDTH(W), .GAP(0), .CNT_W(5)) dutA (
    .clk(clk), .rst(rst), .load(load[0]), .data(data[0]), .ready(rdy[0]),
    .seq(sq[0]), .busy(bz[0]), .done(dn[0]), .bit_cnt(bc[0]));

  seq_gen #(.WIDTH(W), .GAP(3), .CNT_W(5)) dutB (
    .clk(clk), .rst(rst), .load(load[1]), .data(data[1]), .ready(rdy[1]),
    .seq(sq[1]), .busy(bz[1]), .done(dn[1]), .bit_cnt(bc[1]));

`ifdef SEQ_GEN_LOOP_EN
  seq_gen #(.WIDTH(W), .GAP(2), .CNT_W(5)) dutC (
    .clk(clk), .rst(rst), .load(load[2]), .data(data[2]), .ready(rdy[2]),
    .seq(sq[2]), .busy(bz[2]), .done(dn[2]), .bit_cnt(bc[2]));
`endif

  function automatic logic [8:0] obsOf(input int s);
    return {rdy[s], sq[s], bz[s], dn[s], bc[s]};
  endfunction

  // Model: nbits shifted bits of d, then gap idle-zero cycles with ready low.
  function automatic void pushWord(input logic [W-1:0] d, input int nbits, input int gap);
    for (int k = 0; k < nbits; k++)
      expQ.push_back({1'b0, d[k], 1'b1, (k == W - 1), 5'(k)});
    for (int g = 0; g < gap; g++)
      expQ.push_back(9'b0);
  endfunction

  function automatic void pushIdle();
    expQ.push_back({1'b1, 8'b0});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    rst = 1'b0;
    for (int s = 0; s < NI; s++) begin
      load[s] = 1'b1;
      data[s] = '1;
    end
    for (int c = 0; c < 3; c++) begin
      step();
      for (int s = 0; s < NI; s++) begin
        got = obsOf(s);
        numChecks++;
        if (got !== 9'b0) begin
          numFails++;
          $display("[TB] FAIL reset inst%0d cyc%0d got %b expected %b", s, c, got, 9'b0);
        end
      end
    end
    rst = 1'b1;
    for (int s = 0; s < NI; s++) load[s] = 1'b0;
    #1;
    for (int s = 0; s < NI; s++) begin
      numChecks++;
      if (rdy[s] !== 1'b1) begin
        numFails++;
        $display("[TB] FAIL reset_release_ready inst%0d got %b expected 1", s, rdy[s]);
      end
    end
  endtask

  task automatic test_basic();
    logic [8:0] got, exp;
    expQ.delete();
    pushWord(20'h5B6B4, W, 0);
    pushIdle();
    load[0] = 1'b1;
    data[0] = 20'h5B6B4;
    step();
    load[0] = 1'b0;
    for (int i = 0; expQ.size() > 0; i++) begin
      exp = expQ.pop_front();
      got = obsOf(0);
      numChecks++;
      if (got !== exp) begin
        numFails++;
        $display("[TB] FAIL basic[%0d] got %b expected %b", i, got, exp);
      end
      step();
    end
  endtask

  task automatic test_load_while_busy();
    logic [8:0] got, exp;
    expQ.delete();
    pushWord(20'h0A5C3, W, 0);
    pushIdle();
    load[0] = 1'b1;
    data[0] = 20'h0A5C3;
    step();
    load[0] = 1'b0;
    for (int i = 0; expQ.size() > 0; i++) begin
      exp = expQ.pop_front();
      got = obsOf(0);
      numChecks++;
      if (got !== exp) begin
        numFails++;
        $display("[TB] FAIL load_while_busy[%0d] got %b expected %b", i, got, exp);
      end
      load[0] = (i == 7);
      data[0] = 20'hFFFFF;
      step();
    end
    load[0] = 1'b0;
  endtask

  task automatic test_gap();
    logic [8:0] got, exp;
    expQ.delete();
    pushWord(20'hFFFFF, W, 3);
    pushIdle();
    pushWord(20'hFFFFF, W, 3);
    pushIdle();
    load[1] = 1'b1;
    data[1] = 20'hFFFFF;
    step();
    load[1] = 1'b0;
    for (int i = 0; expQ.size() > 0; i++) begin
      exp = expQ.pop_front();
      got = obsOf(1);
      numChecks++;
      if (got !== exp) begin
        numFails++;
        $display("[TB] FAIL gap[%0d] got %b expected %b", i, got, exp);
      end
      load[1] = (i == 23);
      step();
    end
    load[1] = 1'b0;
  endtask

  task automatic test_reset_midword();
    logic [8:0] got, exp;
    expQ.delete();
    pushWord(20'hABCDE, 11, 0);
    expQ.push_back(9'b0);
    load[0] = 1'b1;
    data[0] = 20'hABCDE;
    step();
    load[0] = 1'b0;
    for (int i = 0; expQ.size() > 0; i++) begin
      exp = expQ.pop_front();
      got = obsOf(0);
      numChecks++;
      if (got !== exp) begin
        numFails++;
        $display("[TB] FAIL reset_midword[%0d] got %b expected %b", i, got, exp);
      end
      if (i == 10) rst = 1'b0;
      step();
    end
    expQ.delete();
    pushWord(20'h00003, W, 0);
    pushIdle();
    rst = 1'b1;
    load[0] = 1'b1;
    data[0] = 20'h00003;
    step();
    load[0] = 1'b0;
    for (int i = 0; expQ.size() > 0; i++) begin
      exp = expQ.pop_front();
      got = obsOf(0);
      numChecks++;
      if (got !== exp) begin
        numFails++;
        $display("[TB] FAIL restart[%0d] got %b expected %b", i, got, exp);
      end
      step();
    end
  endtask

`ifdef SEQ_GEN_LOOP_EN
  task automatic test_loop();
    logic [8:0] got, exp;
    expQ.delete();
    for (int r = 0; r < 3; r++) pushWord(20'h00001, W, 2);
    load[2] = 1'b1;
    data[2] = 20'h00001;
    step();
    load[2] = 1'b0;
    for (int i = 0; expQ.size() > 0; i++) begin
      exp = expQ.pop_front();
      got = obsOf(2);
      numChecks++;
      if (got !== exp) begin
        numFails++;
        $display("[TB] FAIL loop[%0d] got %b expected %b", i, got, exp);
      end
      step();
    end
  endtask
`endif

  initial begin
    for (int s = 0; s < NI; s++) begin
      load[s] = 1'b0;
      data[s] = '0;
    end
    rst = 1'b0;
    test_reset();
`ifdef SEQ_GEN_LOOP_EN
    test_loop();
`else
    test_basic();
    test_load_while_busy();
    test_gap();
    test_reset_midword();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at time %0t, expected end before 200000", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
